// File: rtl/ysyx_23060061_mem_arbiter.sv
// Two-master (IFU=m0, LSU=m1) to one-slave memory arbiter, one transaction in flight; ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: grant at T, slave request T+1, earliest master response T+3, earliest next grant T+4.
// Backpressure: loser sees req_ready=0 and holds; slave/master stalls hold state, watchdog turns a stalled slave into err.
module ysyx_23060061_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic                m0_req_wen,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic [DATA_W/8-1:0] m0_req_wstrb,
    output logic                m0_rsp_valid,
    input  logic                m0_rsp_ready,
    output logic [DATA_W-1:0]   m0_rsp_rdata,
    output logic                m0_rsp_err,
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic                m1_req_wen,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_wstrb,
    output logic                m1_rsp_valid,
    input  logic                m1_rsp_ready,
    output logic [DATA_W-1:0]   m1_rsp_rdata,
    output logic                m1_rsp_err,
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_wen,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [DATA_W/8-1:0] s_req_wstrb,
    input  logic                s_rsp_valid,
    output logic                s_rsp_ready,
    input  logic [DATA_W-1:0]   s_rsp_rdata,
    input  logic                s_rsp_err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state;
    logic              owner;
    logic              pend_drop;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic grant_en;
    logic pick1;
    logic any_grant;
    logic timeout;
    logic owner_rsp_ready;

    // Gating with rst keeps req_ready at its reset value while reset is held.
    assign grant_en = rst && (state == S_IDLE) && !pend_drop;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
    assign pick1 = m1_req_valid && (!m0_req_valid || !last_grant);
`else
    assign pick1 = m1_req_valid;
`endif

    assign m1_req_ready    = grant_en && pick1;
    assign m0_req_ready    = grant_en && m0_req_valid && !pick1;
    assign any_grant       = m0_req_ready || m1_req_ready;
    assign timeout         = (cnt == CNT_LAST);
    assign owner_rsp_ready = owner ? m1_rsp_ready : m0_rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            pend_drop <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            // A late response after a WAIT timeout is swallowed here.
            if (pend_drop && s_rsp_valid) begin
                pend_drop <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (any_grant) begin
                        owner   <= m1_req_ready;
                        addr_q  <= m1_req_ready ? m1_req_addr  : m0_req_addr;
                        wen_q   <= m1_req_ready ? m1_req_wen   : m0_req_wen;
                        wdata_q <= m1_req_ready ? m1_req_wdata : m0_req_wdata;
                        wstrb_q <= m1_req_ready ? m1_req_wstrb : m0_req_wstrb;
                        cnt     <= '0;
                        state   <= S_SEND;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= m1_req_ready;
`endif
                    end
                end
                S_SEND: begin
                    cnt <= cnt + 1'b1;
                    if (s_req_ready) begin
                        state <= S_WAIT;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (s_rsp_valid) begin
                        rdata_q <= s_rsp_rdata;
                        err_q   <= s_rsp_err;
                        state   <= S_RESP;
                    end else if (timeout) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        pend_drop <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                default: begin
                    if (owner_rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign s_req_valid  = (state == S_SEND);
    assign s_req_addr   = addr_q;
    assign s_req_wen    = wen_q;
    assign s_req_wdata  = wdata_q;
    assign s_req_wstrb  = wstrb_q;
    assign s_rsp_ready  = (state == S_WAIT) || pend_drop;

    assign m0_rsp_valid = (state == S_RESP) && !owner;
    assign m1_rsp_valid = (state == S_RESP) && owner;
    assign m0_rsp_rdata = rdata_q;
    assign m1_rsp_rdata = rdata_q;
    assign m0_rsp_err   = err_q;
    assign m1_rsp_err   = err_q;
endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Bench for ysyx_23060061_mem_arbiter: instance 0 uses TIMEOUT=255, instance 1 uses TIMEOUT=8; sel picks the one under test.
`timescale 1ns/1ps
module tb_ysyx_23060061_mem_arbiter;
    localparam int TO_SHORT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic sel   = 1'b0;

    logic        m0_req_valid, m0_req_wen, m0_rsp_ready;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic [3:0]  m0_req_wstrb;
    logic        m1_req_valid, m1_req_wen, m1_rsp_ready;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic [3:0]  m1_req_wstrb;
    logic        s_req_ready, s_rsp_valid, s_rsp_err;
    logic [31:0] s_rsp_rdata;

    logic [1:0]  m0_req_ready_w, m1_req_ready_w, m0_rsp_valid_w, m1_rsp_valid_w;
    logic [1:0]  m0_rsp_err_w, m1_rsp_err_w, s_req_valid_w, s_req_wen_w, s_rsp_ready_w;
    logic [31:0] m0_rsp_rdata_w [2];
    logic [31:0] m1_rsp_rdata_w [2];
    logic [31:0] s_req_addr_w [2];
    logic [31:0] s_req_wdata_w [2];
    logic [3:0]  s_req_wstrb_w [2];

    wire        m0_req_ready = m0_req_ready_w[sel];
    wire        m1_req_ready = m1_req_ready_w[sel];
    wire        m0_rsp_valid = m0_rsp_valid_w[sel];
    wire        m1_rsp_valid = m1_rsp_valid_w[sel];
    wire        m0_rsp_err   = m0_rsp_err_w[sel];
    wire        m1_rsp_err   = m1_rsp_err_w[sel];
    wire [31:0] m0_rsp_rdata = m0_rsp_rdata_w[sel];
    wire [31:0] m1_rsp_rdata = m1_rsp_rdata_w[sel];
    wire        s_req_valid  = s_req_valid_w[sel];
    wire        s_req_wen    = s_req_wen_w[sel];
    wire        s_rsp_ready  = s_rsp_ready_w[sel];
    wire [31:0] s_req_addr   = s_req_addr_w[sel];
    wire [31:0] s_req_wdata  = s_req_wdata_w[sel];
    wire [3:0]  s_req_wstrb  = s_req_wstrb_w[sel];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_23060061_mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .TIMEOUT(g == 0 ? 255 : TO_SHORT)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .m0_req_valid (m0_req_valid && (sel == 1'(g))),
            .m0_req_ready (m0_req_ready_w[g]),
            .m0_req_addr  (m0_req_addr),
            .m0_req_wen   (m0_req_wen),
            .m0_req_wdata (m0_req_wdata),
            .m0_req_wstrb (m0_req_wstrb),
            .m0_rsp_valid (m0_rsp_valid_w[g]),
            .m0_rsp_ready (m0_rsp_ready),
            .m0_rsp_rdata (m0_rsp_rdata_w[g]),
            .m0_rsp_err   (m0_rsp_err_w[g]),
            .m1_req_valid (m1_req_valid && (sel == 1'(g))),
            .m1_req_ready (m1_req_ready_w[g]),
            .m1_req_addr  (m1_req_addr),
            .m1_req_wen   (m1_req_wen),
            .m1_req_wdata (m1_req_wdata),
            .m1_req_wstrb (m1_req_wstrb),
            .m1_rsp_valid (m1_rsp_valid_w[g]),
            .m1_rsp_ready (m1_rsp_ready),
            .m1_rsp_rdata (m1_rsp_rdata_w[g]),
            .m1_rsp_err   (m1_rsp_err_w[g]),
            .s_req_valid  (s_req_valid_w[g]),
            .s_req_ready  (s_req_ready),
            .s_req_addr   (s_req_addr_w[g]),
            .s_req_wen    (s_req_wen_w[g]),
            .s_req_wdata  (s_req_wdata_w[g]),
            .s_req_wstrb  (s_req_wstrb_w[g]),
            .s_rsp_valid  (s_rsp_valid && (sel == 1'(g))),
            .s_rsp_ready  (s_rsp_ready_w[g]),
            .s_rsp_rdata  (s_rsp_rdata),
            .s_rsp_err    (s_rsp_err)
        );
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        m0_req_valid = 0; m0_req_wen = 0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_wstrb = '0; m0_rsp_ready = 0;
        m1_req_valid = 0; m1_req_wen = 0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_wstrb = '0; m1_rsp_ready = 0;
        s_req_ready = 0; s_rsp_valid = 0; s_rsp_err = 0; s_rsp_rdata = '0;
    endtask

    // Leaves the bench at the drive point (just after a rising edge).
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        @(negedge clk);
        total++;
        if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready} !== 6'b0)
            begin bad++; $display("FAIL reset_handshake got=%b exp=000000", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready}); end
        total++;
        if ({s_req_addr, s_req_wdata, s_req_wstrb, s_req_wen, m0_rsp_rdata, m0_rsp_err, m1_rsp_err} !== '0)
            begin bad++; $display("FAIL reset_regs addr=%h wdata=%h rdata=%h err=%b exp=0", s_req_addr, s_req_wdata, m0_rsp_rdata, m0_rsp_err); end
        next_cycle();
    endtask

    task automatic test_single_read();
        sel = 0;
        do_reset();
        s_req_ready = 1; m0_rsp_ready = 1;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0000; m0_req_wen = 0;
        @(negedge clk);
        total++;
        if ({m0_req_ready, m1_req_ready} !== 2'b10)
            begin bad++; $display("FAIL single_grant got=%b exp=10", {m0_req_ready, m1_req_ready}); end
        next_cycle();
        m0_req_valid = 0;
        @(negedge clk);
        total++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000 || s_req_wen !== 1'b0)
            begin bad++; $display("FAIL single_sreq valid=%b addr=%h wen=%b exp=1 80000000 0", s_req_valid, s_req_addr, s_req_wen); end
        next_cycle();
        s_rsp_valid = 1; s_rsp_rdata = 32'h1234_5678; s_rsp_err = 0;
        @(negedge clk);
        total++;
        if (s_rsp_ready !== 1'b1 || m0_rsp_valid !== 1'b0)
            begin bad++; $display("FAIL single_wait s_rsp_ready=%b m0_rsp_valid=%b exp=1 0", s_rsp_ready, m0_rsp_valid); end
        next_cycle();
        s_rsp_valid = 0; s_rsp_rdata = '0;
        @(negedge clk);
        total++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'h1234_5678 || m0_rsp_err !== 1'b0)
            begin bad++; $display("FAIL single_rsp valid=%b rdata=%h err=%b exp=1 12345678 0", m0_rsp_valid, m0_rsp_rdata, m0_rsp_err); end
        total++;
        if (m1_rsp_valid !== 1'b0 || m1_req_ready !== 1'b0)
            begin bad++; $display("FAIL single_m1_idle rsp_valid=%b req_ready=%b exp=0 0", m1_rsp_valid, m1_req_ready); end
        next_cycle();
        @(negedge clk);
        total++;
        if (m0_rsp_valid !== 1'b0 || s_req_valid !== 1'b0)
            begin bad++; $display("FAIL single_done rsp_valid=%b s_req_valid=%b exp=0 0", m0_rsp_valid, s_req_valid); end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        int exp_w[3];
        int n, last_cyc;
`ifdef ARB_ROUND_ROBIN_EN
        exp_w = '{0, 1, 0};
`else
        exp_w = '{1, 1, 1};
`endif
        sel = 0;
        do_reset();
        s_req_ready = 1; s_rsp_valid = 1; s_rsp_rdata = 32'h0000_00AA;
        m0_rsp_ready = 1; m1_rsp_ready = 1;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0004;
        m1_req_valid = 1; m1_req_addr = 32'h8000_0008;
        n = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
            @(negedge clk);
            if (m0_req_ready || m1_req_ready) begin
                total++;
                if (int'(m1_req_ready) != exp_w[n] || (m0_req_ready && m1_req_ready))
                    begin bad++; $display("FAIL simul_grant%0d got m0=%b m1=%b exp_master=%0d", n, m0_req_ready, m1_req_ready, exp_w[n]); end
                if (n > 0) begin
                    total++;
                    if (cyc - last_cyc != 4)
                        begin bad++; $display("FAIL simul_spacing%0d got=%0d exp=4", n, cyc - last_cyc); end
                end
                last_cyc = cyc;
                n++;
            end
            next_cycle();
        end
        total++;
        if (n != 3) begin bad++; $display("FAIL simul_count got=%0d exp=3", n); end
        idle_inputs();
    endtask

    // WAIT timeout, then the late response is dropped and grants stay blocked until it arrives.
    task automatic test_timeout_wait();
        logic early_ok, blocked_ok;
        sel = 1;
        do_reset();
        s_req_ready = 1; m0_rsp_ready = 1; m1_rsp_ready = 1;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0010;
        @(negedge clk);
        total++;
        if (m0_req_ready !== 1'b1) begin bad++; $display("FAIL to_grant got=%b exp=1", m0_req_ready); end
        next_cycle();
        m0_req_valid = 0;
        early_ok = 1;
        for (int k = 1; k <= TO_SHORT; k++) begin
            @(negedge clk);
            if (m0_rsp_valid !== 1'b0) early_ok = 0;
            next_cycle();
        end
        total++;
        if (!early_ok) begin bad++; $display("FAIL to_early_rsp got=1 exp=0"); end
        @(negedge clk);
        total++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_err !== 1'b1 || m0_rsp_rdata !== 32'h0)
            begin bad++; $display("FAIL to_rsp valid=%b err=%b rdata=%h exp=1 1 00000000", m0_rsp_valid, m0_rsp_err, m0_rsp_rdata); end
        total++;
        if (s_rsp_ready !== 1'b1) begin bad++; $display("FAIL to_drop_ready got=%b exp=1", s_rsp_ready); end
        next_cycle();
        m1_req_valid = 1; m1_req_addr = 32'h8000_0020;
        blocked_ok = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (m1_req_ready !== 1'b0 || s_rsp_ready !== 1'b1) blocked_ok = 0;
            next_cycle();
        end
        total++;
        if (!blocked_ok) begin bad++; $display("FAIL to_blocked got=granted_or_not_draining exp=blocked"); end
        s_rsp_valid = 1; s_rsp_rdata = 32'hDEAD_0001;
        @(negedge clk);
        total++;
        if (m1_req_ready !== 1'b0 || m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b0)
            begin bad++; $display("FAIL to_discard ready=%b rsp=%b%b exp=0 00", m1_req_ready, m0_rsp_valid, m1_rsp_valid); end
        next_cycle();
        s_rsp_valid = 0;
        @(negedge clk);
        total++;
        if (m1_req_ready !== 1'b1 || s_rsp_ready !== 1'b0)
            begin bad++; $display("FAIL to_regrant ready=%b s_rsp_ready=%b exp=1 0", m1_req_ready, s_rsp_ready); end
        next_cycle();
        m1_req_valid = 0;
        @(negedge clk);
        next_cycle();
        s_rsp_valid = 1; s_rsp_rdata = 32'h0BAD_BEEF;
        @(negedge clk);
        next_cycle();
        s_rsp_valid = 0;
        @(negedge clk);
        total++;
        if (m1_rsp_valid !== 1'b1 || m1_rsp_rdata !== 32'h0BAD_BEEF || m1_rsp_err !== 1'b0 || m0_rsp_valid !== 1'b0)
            begin bad++; $display("FAIL to_after valid=%b rdata=%h err=%b exp=1 0badbeef 0", m1_rsp_valid, m1_rsp_rdata, m1_rsp_err); end
        next_cycle();
        idle_inputs();
    endtask

    // Response arrives in the very cycle the watchdog expires: the response wins.
    task automatic test_timeout_edge();
        logic early_ok;
        sel = 1;
        do_reset();
        s_req_ready = 1; m0_rsp_ready = 1;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0030;
        @(negedge clk);
        next_cycle();
        m0_req_valid = 0;
        early_ok = 1;
        for (int k = 1; k <= TO_SHORT; k++) begin
            s_rsp_valid = (k == TO_SHORT); s_rsp_rdata = 32'hCAFE_F00D; s_rsp_err = 1;
            @(negedge clk);
            if (m0_rsp_valid !== 1'b0) early_ok = 0;
            next_cycle();
        end
        s_rsp_valid = 0; s_rsp_err = 0;
        total++;
        if (!early_ok) begin bad++; $display("FAIL edge_early got=1 exp=0"); end
        @(negedge clk);
        total++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'hCAFE_F00D || m0_rsp_err !== 1'b1 || s_rsp_ready !== 1'b0)
            begin bad++; $display("FAIL edge_rsp valid=%b rdata=%h err=%b s_rsp_ready=%b exp=1 cafef00d 1 0", m0_rsp_valid, m0_rsp_rdata, m0_rsp_err, s_rsp_ready); end
        next_cycle();
        m1_req_valid = 1;
        @(negedge clk);
        total++;
        if (m1_req_ready !== 1'b1) begin bad++; $display("FAIL edge_no_drop ready=%b exp=1", m1_req_ready); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_timeout_send();
        logic send_ok;
        sel = 1;
        do_reset();
        s_req_ready = 0; m0_rsp_ready = 1;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0040;
        @(negedge clk);
        next_cycle();
        m0_req_valid = 0;
        send_ok = 1;
        for (int k = 1; k <= TO_SHORT; k++) begin
            @(negedge clk);
            if (s_req_valid !== 1'b1 || m0_rsp_valid !== 1'b0) send_ok = 0;
            next_cycle();
        end
        total++;
        if (!send_ok) begin bad++; $display("FAIL send_hold got=bad_phase exp=send"); end
        @(negedge clk);
        total++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_err !== 1'b1 || m0_rsp_rdata !== 32'h0 || s_req_valid !== 1'b0 || s_rsp_ready !== 1'b0)
            begin bad++; $display("FAIL send_to valid=%b err=%b rdata=%h s_req_valid=%b s_rsp_ready=%b exp=1 1 0 0 0", m0_rsp_valid, m0_rsp_err, m0_rsp_rdata, s_req_valid, s_rsp_ready); end
        next_cycle();
        m1_req_valid = 1;
        @(negedge clk);
        total++;
        if (m1_req_ready !== 1'b1) begin bad++; $display("FAIL send_regrant ready=%b exp=1", m1_req_ready); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        sel = 0;
        do_reset();
        s_req_ready = 1; m0_rsp_ready = 1;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0050;
        @(negedge clk);
        next_cycle();
        m0_req_valid = 0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        total++;
        if (s_rsp_ready !== 1'b1) begin bad++; $display("FAIL mid_wait s_rsp_ready=%b exp=1", s_rsp_ready); end
        #2;
        m0_req_valid = 1;
        rst = 0;
        #1;
        total++;
        if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready} !== 6'b0)
            begin bad++; $display("FAIL mid_reset got=%b exp=000000", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready}); end
        next_cycle();
        rst = 1;
        s_rsp_valid = 1; s_rsp_rdata = 32'h55AA_33CC;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (k == 0 && m0_req_ready !== 1'b1)
                begin bad++; $display("FAIL mid_regrant ready=%b exp=1", m0_req_ready); end
            else if (k != 0 && (m0_rsp_valid !== (k == 3) || (k == 3 && m0_rsp_rdata !== 32'h55AA_33CC)))
                begin bad++; $display("FAIL mid_after%0d valid=%b rdata=%h exp=%b 55aa33cc", k, m0_rsp_valid, m0_rsp_rdata, k == 3); end
            next_cycle();
            m0_req_valid = 0;
        end
        idle_inputs();
    endtask

    // 1000 random reads/writes from both masters, random-latency slave, reference memory kept by the bench.
    task automatic test_random();
        logic [31:0] ref_mem [16];
        logic [31:0] slv_mem [16];
        logic        act [2];
        logic [31:0] a_addr [2];
        logic [31:0] a_wdata [2];
        logic        a_wen [2];
        logic [3:0]  a_strb [2];
        logic        busy, owner, e_wen, s_pend;
        logic [31:0] e_addr, e_wdata, e_rdata, s_data;
        logic [3:0]  e_strb;
        logic [1:0]  exp_rdy;
        int          s_dly, done, cyc, w;
`ifdef ARB_ROUND_ROBIN_EN
        int          rr_last;
        rr_last = 1;
`endif
        sel = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; slv_mem[i] = ref_mem[i]; end
        act = '{0, 0};
        busy = 0; owner = 0; s_pend = 0; s_dly = 0; done = 0; cyc = 0;
        e_wen = 0; e_addr = '0; e_wdata = '0; e_rdata = '0; e_strb = '0; s_data = '0;
        while (done < 1000 && cyc < 80000) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 2) != 0) begin
                    act[m]     = 1;
                    a_addr[m]  = 32'h8000_0000 + 32'($urandom_range(0, 15) << 2);
                    a_wen[m]   = 1'($urandom_range(0, 1));
                    a_wdata[m] = $urandom;
                    a_strb[m]  = 4'($urandom_range(0, 15));
                end
            end
            m0_req_valid = act[0]; m0_req_addr = a_addr[0]; m0_req_wen = a_wen[0]; m0_req_wdata = a_wdata[0]; m0_req_wstrb = a_strb[0];
            m1_req_valid = act[1]; m1_req_addr = a_addr[1]; m1_req_wen = a_wen[1]; m1_req_wdata = a_wdata[1]; m1_req_wstrb = a_strb[1];
            m0_rsp_ready = ($urandom_range(0, 3) != 0);
            m1_rsp_ready = ($urandom_range(0, 3) != 0);
            s_req_ready  = 1'($urandom_range(0, 1));
            if (s_pend && s_dly == 0) begin
                s_rsp_valid = 1; s_rsp_rdata = s_data;
            end else begin
                if (s_pend) s_dly--;
                s_rsp_valid = 0; s_rsp_rdata = '0;
            end
            @(negedge clk);
            cyc++;
            exp_rdy = 2'b00;
            if (!busy && (m0_req_valid || m1_req_valid)) begin
                if (m0_req_valid && m1_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = 1 - rr_last;
`else
                    w = 1;
`endif
                end else begin
                    w = m1_req_valid ? 1 : 0;
                end
                exp_rdy = (w == 1) ? 2'b10 : 2'b01;
            end
            total++;
            if ({m1_req_ready, m0_req_ready} !== exp_rdy)
                begin bad++; $display("FAIL rnd_arb cyc=%0d got=%b exp=%b busy=%b", cyc, {m1_req_ready, m0_req_ready}, exp_rdy, busy); end
            if (m0_req_ready || m1_req_ready) begin
                owner = m1_req_ready;
                w = int'(owner);
`ifdef ARB_ROUND_ROBIN_EN
                rr_last = w;
`endif
                busy = 1;
                e_addr = a_addr[w]; e_wen = a_wen[w]; e_wdata = a_wdata[w]; e_strb = a_strb[w];
                e_rdata = ref_mem[e_addr[5:2]];
                if (e_wen) ref_mem[e_addr[5:2]] = merge(ref_mem[e_addr[5:2]], e_wdata, e_strb);
                act[w] = 0;
            end
            if (s_req_valid && s_req_ready) begin
                total++;
                if (!busy || s_pend || s_req_addr !== e_addr || s_req_wen !== e_wen || s_req_wdata !== e_wdata || s_req_wstrb !== e_strb)
                    begin bad++; $display("FAIL rnd_sreq cyc=%0d addr=%h wen=%b wdata=%h strb=%h exp=%h %b %h %h", cyc, s_req_addr, s_req_wen, s_req_wdata, s_req_wstrb, e_addr, e_wen, e_wdata, e_strb); end
                if (s_req_wen) begin
                    slv_mem[s_req_addr[5:2]] = merge(slv_mem[s_req_addr[5:2]], s_req_wdata, s_req_wstrb);
                    s_data = $urandom;
                end else begin
                    s_data = slv_mem[s_req_addr[5:2]];
                end
                s_pend = 1;
                s_dly  = int'($urandom_range(0, 40));
            end
            if (s_rsp_valid && s_rsp_ready) s_pend = 0;
            if (m0_rsp_valid || m1_rsp_valid) begin
                total++;
                if (!busy || (m0_rsp_valid && m1_rsp_valid) || m1_rsp_valid !== owner)
                    begin bad++; $display("FAIL rnd_rsp_owner cyc=%0d got=%b%b exp_owner=%b busy=%b", cyc, m1_rsp_valid, m0_rsp_valid, owner, busy); end
                if ((m0_rsp_valid && m0_rsp_ready) || (m1_rsp_valid && m1_rsp_ready)) begin
                    total++;
                    if ((m1_rsp_valid ? m1_rsp_err : m0_rsp_err) !== 1'b0 ||
                        (!e_wen && (m1_rsp_valid ? m1_rsp_rdata : m0_rsp_rdata) !== e_rdata))
                        begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h err=%b exp=%h err=0", cyc, m1_rsp_valid ? m1_rsp_rdata : m0_rsp_rdata, m1_rsp_valid ? m1_rsp_err : m0_rsp_err, e_rdata); end
                    busy = 0;
                    done++;
                end
            end
            next_cycle();
        end
        total++;
        if (done != 1000) begin bad++; $display("FAIL rnd_complete got=%0d exp=1000", done); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_timeout_wait();
        test_timeout_edge();
        test_timeout_send();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout got=stalled exp=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
